core_bus_responder: RTL and testbench

- Bus target (responder) for the core's single-master memory bus: bus_addr / bus_start / bus_write / bus_data_wr / bus_data_be in; bus_ready / bus_data_rd out.
- Wraps an on-chip word-addressed RAM with per-byte write enables and programmable wait states.
- Sits at the far side of core_arbiter's bus port. Serves as the simulation/FPGA main memory behind the arm810 core.

---
 rtl/core_bus_responder_pkg.sv | 17 +
 rtl/core_bus_ram.sv | 33 +++
 rtl/core_bus_responder.sv | 98 +++++++++
 tb/tb_core_bus_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_responder_pkg.sv
// core_bus_responder_pkg: shared bus types, request record and limits for the memory responder
//   ptr      30-bit word address
//   word     32-bit data word
//   bus_req  request fields sampled on an accepted start
//   state_e  responder FSM states
package core_bus_responder_pkg;
    typedef logic [29:0] ptr;
    typedef logic [31:0] word;
    typedef struct packed {
        ptr         addr;
        logic       write;
        word        data;
        logic [3:0] be;
    } bus_req;
    localparam int BUS_LATENCY_MAX = 15;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/core_bus_ram.sv
// core_bus_ram: single-port synchronous word RAM with byte-lane writes and a registered read port
//   clk, rst_n  clock / async active-low reset (read register only; array is not reset)
//   we_i, re_i  write / read strobes for this edge
//   addr_i      word index
//   wdata_i     write data, be_i byte-lane enables
//   rdata_o     registered read data, changes only on a read
module core_bus_ram
    import core_bus_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  word                   wdata_i,
    input  logic [3:0]            be_i,
    output word                   rdata_o
);
    word mem_q [2**DEPTH_LOG2];
    word rdata_q;

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];

    assign rdata_o = rdata_q;
endmodule

// File: rtl/core_bus_responder.sv
// core_bus_responder: memory bus target with programmable wait states in front of an on-chip RAM
//   clk, rst_n                      clock / async active-low reset
//   bus_addr_i, bus_start_i         word address and one-cycle request strobe
//   bus_write_i, bus_data_wr_i      direction and write data, sampled with start
//   bus_data_be_i                   byte-lane enables, sampled with start
//   bus_ready_o                     one-cycle completion strobe, LATENCY cycles after start
//   bus_data_rd_o                   read data, valid with ready of a read and held afterwards
//   busy_o                          a request is outstanding
module core_bus_responder
    import core_bus_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  ptr         bus_addr_i,
    input  logic       bus_start_i,
    input  logic       bus_write_i,
    input  word        bus_data_wr_i,
    input  logic [3:0] bus_data_be_i,
    output logic       bus_ready_o,
    output word        bus_data_rd_o,
    output logic       busy_o
);
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
    localparam state_e     ACC_STATE = (LATENCY == 1) ? RESP : WAIT;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    bus_req     req_q, req_d, bus_in, cur;
    logic       oor_q, oor_d, ready_q, busy_q;
    logic       accept, commit, in_range;
    word        ram_rd;

    assign bus_in = {bus_addr_i, bus_write_i, bus_data_wr_i, bus_data_be_i};
    // A start in RESP is accepted too, which is what gives back-to-back throughput
    assign accept = bus_start_i && state_q != WAIT;
    // The commit edge is the one entering RESP; with single-cycle latency that is the accept edge itself
    assign commit = (state_q == WAIT && cnt_q == 4'd1) || (accept && LATENCY == 1);
    assign cur = (LATENCY == 1) ? bus_in : req_q;
    assign in_range = ~|(cur.addr >> DEPTH_LOG2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        oor_d   = oor_q;
        if (accept) begin
            state_d = ACC_STATE;
            cnt_d   = CNT_INIT;
            req_d   = bus_in;
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : WAIT;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        if (commit && !cur.write) oor_d = !in_range;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            oor_q   <= oor_d;
            ready_q <= state_d == RESP;
            busy_q  <= state_d != IDLE;
        end

    core_bus_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit && cur.write && in_range),
        .re_i    (commit && !cur.write && in_range),
        .addr_i  (cur.addr[DEPTH_LOG2-1:0]),
        .wdata_i (cur.data),
        .be_i    (cur.be),
        .rdata_o (ram_rd)
    );

    assign bus_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign bus_data_rd_o = oor_q ? '0 : ram_rd;

`ifndef SYNTHESIS
    start_in_wait: assert property (@(posedge clk) disable iff (!rst_n) !(bus_start_i && state_q == WAIT))
        else $warning("bus_start ignored while a request is outstanding");
`endif
endmodule

// File: tb/tb_core_bus_responder.sv
// tb_core_bus_responder: randomized and directed checks of core_bus_responder at latencies 1..4
module tb_core_bus_responder;
    import core_bus_responder_pkg::*;
    localparam int NI = 4;

    typedef struct {
        bit         w;
        ptr         a;
        word        d;
        logic [3:0] be;
    } txn_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr = 1'b0;
    ptr addr = '0;
    word wdata = '0;
    logic [3:0] be = '0;
    int sel = 0;
    logic [NI-1:0] rdy, bsy;
    word rd [NI];
    int total = 0, bad = 0;
    txn_t txq[$];
    word mdl [longint];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        core_bus_responder #(.DEPTH_LOG2(12), .LATENCY(g + 1)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .bus_addr_i    (addr),
            .bus_start_i   (start && sel == g),
            .bus_write_i   (wr),
            .bus_data_wr_i (wdata),
            .bus_data_be_i (be),
            .bus_ready_o   (rdy[g]),
            .bus_data_rd_o (rd[g]),
            .busy_o        (bsy[g])
        );
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push(bit w, ptr a, word d, logic [3:0] b);
        txq.push_back('{w, a, d, b});
    endfunction

    function automatic longint key(int k, ptr a);
        return (longint'(k) << 32) | longint'(a);
    endfunction

    function automatic word merge(word old, word d, logic [3:0] b);
        word m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // Drives the queued transactions into instance k; b2b issues the next start in the ready cycle
    task automatic run(int k, bit b2b);
        int since = 0, guard = 0;
        bit outst = 0, cur_w = 0, exp_known = 0, r;
        word exp_d = '0;
        txn_t t;
        longint kk;
        while ((txq.size() > 0 || outst) && guard < 3000) begin
            @(negedge clk);
            guard++;
            since++;
            r = rdy[k];
            if (r) begin
                chk("spurious ready", 64'(outst), 1);
                if (outst) begin
                    chk("latency", since, k + 1);
                    if (!cur_w && exp_known) chk("read data", rd[k], exp_d);
                end
                outst = 0;
            end else if (outst && since > k + 3) begin
                chk("ready timeout", since, k + 1);
                outst = 0;
            end
            start = 1'b0;
            if (!outst && (b2b || !r) && txq.size() > 0) begin
                t = txq.pop_front();
                sel = k; addr = t.a; wr = t.w; wdata = t.d; be = t.be; start = 1'b1;
                outst = 1; since = 0; cur_w = t.w;
                kk = key(k, t.a);
                if (t.w) begin
                    if (t.a < 4096 && (mdl.exists(kk) || t.be == 4'hF))
                        mdl[kk] = merge(mdl.exists(kk) ? mdl[kk] : '0, t.d, t.be);
                end else begin
                    exp_known = t.a >= 4096 || mdl.exists(kk);
                    exp_d = (t.a < 4096 && mdl.exists(kk)) ? mdl[kk] : '0;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("trailing ready", 64'(rdy[k]), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, when;
        ptr a;
        // reset with start held high
        sel = 1; start = 1'b1; wr = 1'b1; wdata = 32'h12345678; be = 4'hF;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset ready", 64'(rdy[k]), 0);
            chk("reset rd", rd[k], 0);
            chk("reset busy", 64'(bsy[k]), 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        // full write then read
        push(1, 30'h10, 32'hDEADBEEF, 4'hF);
        push(0, 30'h10, '0, 4'hF);
        run(1, 0);
        chk("deadbeef hold", rd[1], 32'hDEADBEEF);
        // byte enables and be=0
        push(1, 30'h5, 32'h11223344, 4'hF);
        push(1, 30'h5, 32'hAABBCCDD, 4'b0101);
        push(0, 30'h5, '0, 4'h0);
        push(1, 30'h5, 32'h00000000, 4'h0);
        push(0, 30'h5, '0, 4'hF);
        run(1, 0);
        chk("be merge hold", rd[1], 32'h11BB33DD);
        // out of range, no aliasing onto index 0
        push(1, 30'h0, 32'hCAFEF00D, 4'hF);
        push(1, 30'h1000, 32'hFFFFFFFF, 4'hF);
        push(0, 30'h1000, '0, 4'hF);
        push(0, 30'h0, '0, 4'hF);
        push(0, 30'h1000, '0, 4'hF);
        run(1, 0);
        // back-to-back alternating write/read at latency 1 and 3
        for (int k = 0; k < NI; k += 2) begin
            for (int i = 0; i < 4; i++) begin
                a = ptr'($urandom_range(0, 4095));
                push(1, a, $urandom, 4'hF);
                push(0, a, '0, 4'hF);
            end
            run(k, 1);
        end
        // randomized mix over a small preloaded window, all latencies
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) push(1, ptr'(i), $urandom, 4'hF);
            for (int i = 0; i < 40; i++)
                push(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? ptr'(30'h1000 + i) : ptr'($urandom_range(0, 7)),
                     $urandom, 4'($urandom));
            run(k, 1'($urandom_range(0, 1)));
        end
        // abort a write at latency 4 by reset two cycles after its start
        push(1, 30'h7, 32'h0BADF00D, 4'hF);
        run(3, 0);
        @(negedge clk);
        sel = 3; addr = 30'h7; wr = 1'b1; wdata = 32'h55555555; be = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort early ready", 64'(rdy[3]), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(bsy[3]), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort ready", 64'(rdy[3]), 0);
        end
        rst_n = 1'b1;
        push(0, 30'h7, '0, 4'hF);
        run(3, 0);
        chk("abort not committed", rd[3], 32'h0BADF00D);
        // start during WAIT is ignored
        @(negedge clk);
        sel = 3; addr = 30'h7; wr = 1'b0; be = 4'hF; start = 1'b1;
        n = 0; when = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rdy[3]) begin n++; when = i; end
            start = (i == 1);
            wr = 1'b1; wdata = 32'hFFFF0000;
        end
        start = 1'b0;
        chk("wait start acks", n, 1);
        chk("wait start latency", when, 4);
        chk("wait start data", rd[3], 32'h0BADF00D);
        push(0, 30'h7, '0, 4'hF);
        run(3, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
